// File: rtl/serial_pattern_transmitter.sv
// serial_pattern_transmitter
// Sends a W-bit pattern MSB first on 'a', (reps+1) times. GAP_LEN idle
// cycles separate the repetitions. A one-cycle 'done' pulse follows the
// last bit. Moore FSM: IDLE -> SEND [-> GAP -> SEND ...] -> DONE.
// Optional feature: define SERIAL_PATTERN_TX_ABORT_EN to add an 'abort'
// input. Abort cancels a transfer in SEND or GAP without a done pulse,
// and it overrides start in every state.
module serial_pattern_transmitter #(
  parameter int W       = 6,
  parameter int GAP_LEN = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] pattern,
  input  logic [3:0]   reps,
`ifdef SERIAL_PATTERN_TX_ABORT_EN
  input  logic         abort,
`endif
  output logic         a,
  output logic         a_valid,
  output logic         busy,
  output logic         done
);

  localparam int BW = $clog2(W);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]    rep_cnt_q, rep_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [W-1:0]  pat_q, pat_d;

  logic          abort_w;
  logic          start_ok;
  logic [BW-1:0] bit_idx;

`ifdef SERIAL_PATTERN_TX_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Abort suppresses acceptance of a new transfer in any state.
  assign start_ok = start & ~abort_w;

  // Next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pat_d     = pat_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d   = S_SEND;
          pat_d     = pattern;
          rep_cnt_d = reps;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (abort_w) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end else if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (rep_cnt_q != 4'd0) begin
            rep_cnt_d = rep_cnt_q - 4'd1;
            // With no gap the next repetition starts straight away in SEND.
            if (GAP_LEN > 0) begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      S_GAP: begin
        if (abort_w) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_SEND;
          bit_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      pat_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pat_q     <= pat_d;
    end
  end

  // Outputs decoded from registers only; 'a' is forced low outside SEND.
  always_comb begin
    bit_idx = BIT_LAST - bit_cnt_q;
    a_valid = (state_q == S_SEND);
    a       = a_valid & pat_q[bit_idx];
    busy    = (state_q == S_SEND) || (state_q == S_GAP);
    done    = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_serial_pattern_transmitter.sv
// Scoreboard bench for serial_pattern_transmitter.
// dut0: W=6, GAP_LEN=0; dut1: W=6, GAP_LEN=2. Each stimulus pushes the
// expected output events (bit value or done, plus the cycle stamp) into
// a queue. A monitor pops from that queue whenever a DUT shows a_valid or done.
module tb_serial_pattern_transmitter;

  logic       clk;
  logic       rst;
  logic       start0, start1;
  logic [5:0] pat0, pat1;
  logic [3:0] reps0, reps1;
  logic       a0, av0, busy0, done0;
  logic       a1, av1, busy1, done1;
`ifdef SERIAL_PATTERN_TX_ABORT_EN
  logic       abort0, abort1;
`endif

  typedef struct {
    bit is_done;
    bit val;
    int cyc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 0;

  serial_pattern_transmitter #(.W(6), .GAP_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .pattern(pat0), .reps(reps0),
`ifdef SERIAL_PATTERN_TX_ABORT_EN
    .abort(abort0),
`endif
    .a(a0), .a_valid(av0), .busy(busy0), .done(done0)
  );

  serial_pattern_transmitter #(.W(6), .GAP_LEN(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pattern(pat1), .reps(reps1),
`ifdef SERIAL_PATTERN_TX_ABORT_EN
    .abort(abort1),
`endif
    .a(a1), .a_valid(av1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Expected events for one transfer. A limit below zero means the whole
  // transfer plus its done pulse; otherwise only the first 'limit' bits.
  function automatic void push_xfer(input int id, input logic [5:0] p, input int r,
                                    input int gap, input int base, input int limit);
    int  t = base;
    int  n = 0;
    ev_t e;
    for (int rr = 0; rr <= r; rr++) begin
      for (int k = 0; k < 6; k++) begin
        if (limit < 0 || n < limit) begin
          e.is_done = 1'b0; e.val = p[5-k]; e.cyc = t;
          if (id == 0) q0.push_back(e); else q1.push_back(e);
        end
        t++; n++;
      end
      if (rr < r) t += gap;
    end
    if (limit < 0) begin
      e.is_done = 1'b1; e.val = 1'b0; e.cyc = t;
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
  endfunction

  task automatic mon(input int id, input logic a_i, input logic av_i, input logic d_i);
    ev_t e;
    int  sz;
    if (av_i !== 1'b1) begin
      checks++;
      if (a_i !== 1'b0) begin
        errors++;
        $display("FAIL a_idle_zero dut%0d cyc=%0d: a=%b required 0", id, cyc, a_i);
      end
    end
    if (av_i === 1'b1 || d_i === 1'b1) begin
      checks++;
      sz = (id == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        errors++;
        $display("FAIL unexpected_output dut%0d cyc=%0d: valid=%b a=%b done=%b required none",
                 id, cyc, av_i, a_i, d_i);
      end else begin
        if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
        if ((d_i !== e.is_done) || (e.cyc != cyc) ||
            (!e.is_done && (av_i !== 1'b1 || a_i !== e.val)) ||
            (e.is_done && av_i !== 1'b0)) begin
          errors++;
          $display("FAIL event dut%0d: got valid=%b a=%b done=%b cyc=%0d required done=%b a=%b cyc=%0d",
                   id, av_i, a_i, d_i, cyc, e.is_done, e.val, e.cyc);
        end
      end
    end
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, a0, av0, done0);
      mon(1, a1, av1, done1);
    end
  end

  task automatic drain(input int id);
    int sz;
    for (int i = 0; i < 300; i++) begin
      sz = (id == 0) ? q0.size() : q1.size();
      if (sz == 0) break;
      @(negedge clk); #1;
    end
    sz = (id == 0) ? q0.size() : q1.size();
    checks++;
    if (sz != 0) begin
      errors++;
      $display("FAIL drain_timeout dut%0d: %0d events pending, required 0", id, sz);
      if (id == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic kick(input int id, input logic [5:0] p, input logic [3:0] r, output int base);
    @(negedge clk);
    if (id == 0) begin start0 = 1'b1; pat0 = p; reps0 = r; end
    else begin start1 = 1'b1; pat1 = p; reps1 = r; end
    @(posedge clk); #1;
    base = cyc;
    if (id == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    pat0 = '0; pat1 = '0; reps0 = '0; reps1 = '0;
`ifdef SERIAL_PATTERN_TX_ABORT_EN
    abort0 = 1'b0; abort1 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_dut0_outputs", {28'd0, a0, av0, busy0, done0}, 32'd0);
    chk("reset_dut1_outputs", {28'd0, a1, av1, busy1, done1}, 32'd0);
    mon_en = 1'b1;

    // Single pattern, start in the same cycle rst is released.
    @(negedge clk);
    rst = 1'b1; start0 = 1'b1; pat0 = 6'b110011; reps0 = 4'd0;
    @(posedge clk); #1;
    c = cyc; start0 = 1'b0;
    push_xfer(0, 6'b110011, 0, 0, c, -1);
    drain(0);
    @(posedge clk); #1;
    chk("idle_after_done_dut0", {29'd0, av0, busy0, done0}, 32'd0);

    // Three back-to-back repetitions without gap.
    kick(0, 6'b101000, 4'd2, c);
    push_xfer(0, 6'b101000, 2, 0, c, -1);
    drain(0);

    // Two repetitions with a two-cycle gap.
    kick(1, 6'b111111, 4'd1, c);
    push_xfer(1, 6'b111111, 1, 2, c, -1);
    repeat (7) @(negedge clk);
    chk("gap0_busy_novalid", {30'd0, busy1, av1}, 32'd2);
    @(negedge clk);
    chk("gap1_busy_novalid", {30'd0, busy1, av1}, 32'd2);
    drain(1);

    // start held high: ignored while busy, re-accepted in DONE.
    @(negedge clk);
    start0 = 1'b1; pat0 = 6'b100101; reps0 = 4'd0;
    @(posedge clk); #1;
    c = cyc;
    push_xfer(0, 6'b100101, 0, 0, c, -1);
    push_xfer(0, 6'b010110, 0, 0, c + 7, -1);
    repeat (3) @(negedge clk);
    pat0 = 6'b010110;
    repeat (6) @(negedge clk);
    start0 = 1'b0;
    drain(0);
    @(posedge clk); #1;
    chk("idle_after_held_start", {30'd0, busy0, av0}, 32'd0);

    // Asynchronous reset at bit 3 aborts the transfer.
    kick(0, 6'b110011, 4'd1, c);
    push_xfer(0, 6'b110011, 1, 0, c, 3);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {28'd0, a0, av0, busy0, done0}, 32'd0);
    chk("async_reset_pending", q0.size(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    kick(0, 6'b011010, 4'd0, c);
    push_xfer(0, 6'b011010, 0, 0, c, -1);
    drain(0);

`ifdef SERIAL_PATTERN_TX_ABORT_EN
    // Abort during the second repetition of four.
    kick(0, 6'b110011, 4'd3, c);
    push_xfer(0, 6'b110011, 3, 0, c, 8);
    repeat (7) @(posedge clk);
    #1;
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    chk("abort_idle", {29'd0, busy0, av0, done0}, 32'd0);
    drain(0);
`endif

    repeat (40) @(negedge clk);
    chk("final_q0_empty", q0.size(), 32'd0);
    chk("final_q1_empty", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
